// File: rtl/fifo_order_arbiter_pkg.sv
// Shared definitions for the first-come-first-served arbiter family:
// tie-break mode encodings and a constant-foldable log2 helper used to
// size id and occupancy fields from the requester count.
package arb_pkg;

    // Same-cycle arrivals: lowest index first.
    localparam int TIE_FIXED  = 0;
    // Same-cycle arrivals: start after the last granted id, wrapping at N-1.
    localparam int TIE_ROTATE = 1;

    // Ceiling log2. clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_order_arbiter_arrival_order.sv
// Orders the requesters that newly arrive on one edge. The output list is
// packed from slot 0: order[0] is the first arrival to be appended to the
// queue, order[count-1] the last. Slots at or beyond count read as zero.
module arrival_order
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N),
    parameter int CW  = clog2(N + 1)
) (
    input  logic [N-1:0]          arrivals,
    input  logic [IDW-1:0]        start,
    input  logic                  rotate,
    output logic [N-1:0][IDW-1:0] order,
    output logic [CW-1:0]         count
);

    // Scan requesters from the chosen start index, wrapping once, and place
    // each arrival into the next free output slot.
    always_comb begin
        int base;
        int idx;
        int n;
        order = '0;
        n     = 0;
        base  = rotate ? int'(start) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (arrivals[idx]) begin
                for (int j = 0; j < N; j++) begin
                    if (j == n) begin
                        order[j] = IDW'(idx);
                    end
                end
                n = n + 1;
            end
        end
        count = CW'(n);
    end

endmodule

// File: rtl/fifo_order_arbiter.sv
// First-come-first-served arbiter for N level-sensitive requesters.
// Requesters join a queue when their req rises and leave it the first edge
// their req is sampled low, from any position. The queue head owns the
// grant for as long as it keeps req high; there is no timeout.
//
// Grant semantics: gnt/gnt_id/gnt_valid are decoded only from registered
// state, so a requester sees its grant one edge after its req is sampled
// and there is no combinational path from req to gnt. When the owner drops
// req, the next queued requester is granted after that same edge, with no
// idle cycle in between.
module fifo_order_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int TIE_MODE = TIE_FIXED,
    parameter int IDW      = clog2(N),
    parameter int CW       = clog2(N + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [CW-1:0]  q_count
);

    // Queue storage. Each requester holds at most one slot, so N slots can
    // never overflow. Slots at or beyond count are kept at zero.
    logic [N-1:0][IDW-1:0] q;
    logic [N-1:0][IDW-1:0] q_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [N-1:0]          in_q;
    logic [N-1:0]          in_q_nxt;
    logic [IDW-1:0]        last_id;
    logic [IDW-1:0]        last_id_nxt;

    // Arrival ordering for this edge.
    logic [N-1:0]          arrivals;
    logic [IDW-1:0]        start;
    logic [N-1:0][IDW-1:0] arr_order;
    logic [CW-1:0]         arr_count;

    // A requester arrives when it asks and is not already queued. Rotation
    // starts one past the id that currently holds (or last held) the grant.
    always_comb begin
        arrivals = req & ~in_q;
        if (int'(last_id) == N - 1) begin
            start = '0;
        end else begin
            start = last_id + IDW'(1);
        end
    end

    arrival_order #(
        .N   (N),
        .IDW (IDW),
        .CW  (CW)
    ) u_arrival_order (
        .arrivals (arrivals),
        .start    (start),
        .rotate   (TIE_MODE == TIE_ROTATE),
        .order    (arr_order),
        .count    (arr_count)
    );

    // Next queue: drop withdrawn entries and compact survivors toward slot 0
    // keeping their order, then append this edge's arrivals behind them.
    always_comb begin
        int k;
        q_nxt = '0;
        k     = 0;
        for (int pos = 0; pos < N; pos++) begin
            if (pos < int'(count) && req[q[pos]]) begin
                for (int j = 0; j < N; j++) begin
                    if (j == k) begin
                        q_nxt[j] = q[pos];
                    end
                end
                k = k + 1;
            end
        end
        for (int a = 0; a < N; a++) begin
            if (a < int'(arr_count)) begin
                for (int j = 0; j < N; j++) begin
                    if (j == k + a) begin
                        q_nxt[j] = arr_order[a];
                    end
                end
            end
        end
        count_nxt = CW'(k + int'(arr_count));
    end

    // Membership follows the queue: withdrawn ids leave, arrivals join.
    // last_id tracks the head whenever the queue is non-empty so rotation
    // resumes after the most recent owner once the queue drains.
    always_comb begin
        in_q_nxt = (in_q & req) | arrivals;
        if (count_nxt != '0) begin
            last_id_nxt = q_nxt[0];
        end else begin
            last_id_nxt = last_id;
        end
    end

    // State register; reset discards the whole queue at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            count   <= '0;
            in_q    <= '0;
            last_id <= IDW'(N - 1);
        end else begin
            q       <= q_nxt;
            count   <= count_nxt;
            in_q    <= in_q_nxt;
            last_id <= last_id_nxt;
        end
    end

    // Grant decode from the registered head only.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = (count != '0);
        q_count   = count;
        if (gnt_valid) begin
            gnt[q[0]] = 1'b1;
            gnt_id    = q[0];
        end
    end

    // Occupancy must always match the membership bitmap.
    count_matches_members: assert property (
        @(posedge clock) disable iff (!reset)
        count == CW'($countones(in_q))
    );

    // At most one requester is granted at a time.
    grant_onehot: assert property (
        @(posedge clock) disable iff (!reset)
        $onehot0(gnt)
    );

endmodule

// File: tb/tb_fifo_order_arbiter.sv
// Directed bench for fifo_order_arbiter: one instance with fixed tie-break
// and one with rotating tie-break, sharing clock and reset. A table of
// {dut select, req, expected gnt, gnt_id, q_count} records is applied one
// edge per record, followed by hand-written reset sequences.
module tb_fifo_order_arbiter;
    import arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req0;
    logic [N-1:0]   req1;
    logic [N-1:0]   gnt0;
    logic [N-1:0]   gnt1;
    logic           gnt_valid0;
    logic           gnt_valid1;
    logic [IDW-1:0] gnt_id0;
    logic [IDW-1:0] gnt_id1;
    logic [CW-1:0]  q_count0;
    logic [CW-1:0]  q_count1;

    typedef struct packed {
        logic           sel;   // 0: fixed instance, 1: rotating instance
        logic [N-1:0]   req;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    fifo_order_arbiter #(.N(N), .TIE_MODE(TIE_FIXED)) dut_fixed (
        .clock     (clock),
        .reset     (reset),
        .req       (req0),
        .gnt       (gnt0),
        .gnt_valid (gnt_valid0),
        .gnt_id    (gnt_id0),
        .q_count   (q_count0)
    );

    fifo_order_arbiter #(.N(N), .TIE_MODE(TIE_ROTATE)) dut_rotate (
        .clock     (clock),
        .reset     (reset),
        .req       (req1),
        .gnt       (gnt1),
        .gnt_valid (gnt_valid1),
        .gnt_id    (gnt_id1),
        .q_count   (q_count1)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_dut(input logic sel, input string tag, input logic [N-1:0] g,
                             input logic [IDW-1:0] id, input logic [CW-1:0] c);
        if (sel == 1'b0) begin
            check({tag, " gnt"},       32'(gnt0),       32'(g));
            check({tag, " gnt_valid"}, 32'(gnt_valid0), 32'(|g));
            check({tag, " gnt_id"},    32'(gnt_id0),    32'(id));
            check({tag, " q_count"},   32'(q_count0),   32'(c));
        end else begin
            check({tag, " gnt"},       32'(gnt1),       32'(g));
            check({tag, " gnt_valid"}, 32'(gnt_valid1), 32'(|g));
            check({tag, " gnt_id"},    32'(gnt_id1),    32'(id));
            check({tag, " q_count"},   32'(q_count1),   32'(c));
        end
    endtask

    initial begin
        // Fixed instance: req[2] first, req[0] joins, req[2] leaves.
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 3'd1});
        vecs.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 3'd2});
        vecs.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 3'd2});
        vecs.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 3'd2});
        vecs.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 3'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Fixed instance: all four together, drained in index order.
        vecs.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 3'd4});
        vecs.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 3'd3});
        vecs.push_back('{1'b0, 4'b1100, 4'b0100, 2'd2, 3'd2});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 3'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Fixed instance: queue 1,3,2; 3 withdraws mid-queue; next is 2.
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 3'd1});
        vecs.push_back('{1'b0, 4'b1010, 4'b0010, 2'd1, 3'd2});
        vecs.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 3'd3});
        vecs.push_back('{1'b0, 4'b0110, 4'b0010, 2'd1, 3'd2});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 3'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Fixed instance: owner 0 leaves as 3 arrives, no empty cycle.
        vecs.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 3'd1});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 3'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Fixed instance: one-cycle low pulse re-enqueues 0 at the tail.
        vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 3'd2});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 3'd1});
        vecs.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 3'd2});
        vecs.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 3'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Rotating instance: leave last_id = 1, then all four -> 2,3,0,1.
        vecs.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 3'd1});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 3'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 3'd4});
        vecs.push_back('{1'b1, 4'b1011, 4'b1000, 2'd3, 3'd3});
        vecs.push_back('{1'b1, 4'b0011, 4'b0001, 2'd0, 3'd2});
        vecs.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 3'd1});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 3'd0});
        // Rotating instance: after owner 1, arrivals 0 and 2 order as 2,0.
        vecs.push_back('{1'b1, 4'b0101, 4'b0100, 2'd2, 3'd2});
        vecs.push_back('{1'b1, 4'b0001, 4'b0001, 2'd0, 3'd1});
        // Arrivals 1,3 behind owner 0 start at index 1.
        vecs.push_back('{1'b1, 4'b1011, 4'b0001, 2'd0, 3'd3});
        vecs.push_back('{1'b1, 4'b1010, 4'b0010, 2'd1, 3'd2});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 3'd0});

        // Reset block: held low for three edges with no requests.
        reset = 1'b0;
        req0  = '0;
        req1  = '0;
        repeat (3) step();
        check_dut(1'b0, "reset fixed", 4'b0000, 2'd0, 3'd0);
        check_dut(1'b1, "reset rotate", 4'b0000, 2'd0, 3'd0);
        reset = 1'b1;
        step();
        check_dut(1'b0, "idle fixed", 4'b0000, 2'd0, 3'd0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sel == 1'b0) begin
                req0 = vecs[i].req;
            end else begin
                req1 = vecs[i].req;
            end
            step();
            check_dut(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].cnt);
        end

        // Reset mid-ownership: queue 2,0,1 with 2 owning.
        req0 = 4'b0100;
        step();
        check_dut(1'b0, "pre-reset owner", 4'b0100, 2'd2, 3'd1);
        req0 = 4'b0111;
        step();
        check_dut(1'b0, "pre-reset queue", 4'b0100, 2'd2, 3'd3);
        #2;
        reset = 1'b0;
        #1;
        check_dut(1'b0, "async reset", 4'b0000, 2'd0, 3'd0);

        // Requests held through reset enqueue from index 0 after release;
        // the rotating instance must also restart at index 0.
        req0 = 4'b0110;
        req1 = 4'b1001;
        step();
        check_dut(1'b0, "held in reset", 4'b0000, 2'd0, 3'd0);
        reset = 1'b1;
        step();
        check_dut(1'b0, "post-reset fixed", 4'b0010, 2'd1, 3'd2);
        check_dut(1'b1, "post-reset rotate", 4'b0001, 2'd0, 3'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
